// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: run enable in, counters, strobes and VGA sync/valid out.
// The generator holds the master side; a framebuffer/renderer or VGA port holds the slave side.
interface vga_timing_gen_if #(
    parameter int HWIDTH = 12,
    parameter int VWIDTH = 12,
    parameter int FCW    = 16
);
    logic              en;
    logic              pix_tick;
    logic [HWIDTH-1:0] hdata;
    logic [VWIDTH-1:0] vdata;
    logic              line_start;
    logic              frame_start;
    logic [FCW-1:0]    frame_count;
    logic              hsync;
    logic              vsync;
    logic              valid;

    modport master (
        input  en,
        output pix_tick, hdata, vdata, line_start, frame_start, frame_count,
        output hsync, vsync, valid
    );

    modport slave (
        output en,
        input  pix_tick, hdata, vdata, line_start, frame_start, frame_count,
        input  hsync, vsync, valid
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with a pixel-clock divider, stall enable, line/frame strobes,
// a frame counter and a fixed clk-cycle delay line on hsync/vsync/valid.
module vga_timing_gen #(
    parameter int HACTIVE    = 640,
    parameter int HFP_LEN    = 16,
    parameter int HSYNC_LEN  = 96,
    parameter int HBP_LEN    = 48,
    parameter int VACTIVE    = 480,
    parameter int VFP_LEN    = 10,
    parameter int VSYNC_LEN  = 2,
    parameter int VBP_LEN    = 33,
    parameter bit HSPP       = 1'b1,
    parameter bit VSPP       = 1'b1,
    parameter int CLK_DIV    = 1,
    parameter int PIPE_DELAY = 0,
    parameter int HWIDTH     = 12,
    parameter int VWIDTH     = 12,
    parameter int FCW        = 16
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);
    localparam int HMAX = HACTIVE + HFP_LEN + HSYNC_LEN + HBP_LEN;
    localparam int VMAX = VACTIVE + VFP_LEN + VSYNC_LEN + VBP_LEN;
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIVW-1:0]   DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [HWIDTH-1:0] H_LAST   = HWIDTH'(HMAX - 1);
    localparam logic [HWIDTH-1:0] H_ACT    = HWIDTH'(HACTIVE);
    localparam logic [HWIDTH-1:0] HS_START = HWIDTH'(HACTIVE + HFP_LEN);
    localparam logic [HWIDTH-1:0] HS_END   = HWIDTH'(HACTIVE + HFP_LEN + HSYNC_LEN);
    localparam logic [VWIDTH-1:0] V_LAST   = VWIDTH'(VMAX - 1);
    localparam logic [VWIDTH-1:0] V_ACT    = VWIDTH'(VACTIVE);
    localparam logic [VWIDTH-1:0] VS_START = VWIDTH'(VACTIVE + VFP_LEN);
    localparam logic [VWIDTH-1:0] VS_END   = VWIDTH'(VACTIVE + VFP_LEN + VSYNC_LEN);

    generate
        if (longint'(HMAX) > (64'd1 << HWIDTH)) begin : g_chk_hmax
            $error("vga_timing_gen: HMAX does not fit in HWIDTH");
        end
        if (longint'(VMAX) > (64'd1 << VWIDTH)) begin : g_chk_vmax
            $error("vga_timing_gen: VMAX does not fit in VWIDTH");
        end
        if (CLK_DIV < 1) begin : g_chk_div
            $error("vga_timing_gen: CLK_DIV must be >= 1");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_chk_dly
            $error("vga_timing_gen: PIPE_DELAY must be 0..8");
        end
        if (HFP_LEN < 1 || HSYNC_LEN < 1 || HBP_LEN < 1 ||
            VFP_LEN < 1 || VSYNC_LEN < 1 || VBP_LEN < 1) begin : g_chk_len
            $error("vga_timing_gen: porch and sync lengths must be >= 1");
        end
    endgenerate

    function automatic logic sync_level(input logic in_pulse, input logic pol);
        return in_pulse ? pol : ~pol;
    endfunction

    logic [DIVW-1:0]   div_cnt;
    logic [HWIDTH-1:0] hcnt;
    logic [VWIDTH-1:0] vcnt;
    logic [FCW-1:0]    fcnt;
    logic              pix_tick;
    logic              line_start;
    logic              h_end;
    logic              v_end;
    logic              hs_raw;
    logic              vs_raw;
    logic              vld_raw;

    assign pix_tick   = vga.en && (div_cnt == DIV_LAST);
    assign h_end      = (hcnt == H_LAST);
    assign v_end      = (vcnt == V_LAST);
    assign line_start = pix_tick && (hcnt == '0);

    // Divider and raster counters; everything freezes while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            hcnt    <= '0;
            vcnt    <= '0;
            fcnt    <= '0;
        end else if (vga.en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (pix_tick) begin
                hcnt <= h_end ? '0 : hcnt + 1'b1;
                if (h_end) begin
                    vcnt <= v_end ? '0 : vcnt + 1'b1;
                    if (v_end) begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        hs_raw  = sync_level((hcnt >= HS_START) && (hcnt < HS_END), HSPP);
        vs_raw  = sync_level((vcnt >= VS_START) && (vcnt < VS_END), VSPP);
        vld_raw = (hcnt < H_ACT) && (vcnt < V_ACT);
    end

    assign vga.pix_tick    = pix_tick;
    assign vga.hdata       = hcnt;
    assign vga.vdata       = vcnt;
    assign vga.line_start  = line_start;
    assign vga.frame_start = line_start && (vcnt == '0);
    assign vga.frame_count = fcnt;

    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign vga.hsync = hs_raw;
            assign vga.vsync = vs_raw;
            assign vga.valid = vld_raw;
        end else begin : g_dly
            logic [PIPE_DELAY-1:0] hs_p;
            logic [PIPE_DELAY-1:0] vs_p;
            logic [PIPE_DELAY-1:0] vld_p;

            // Delay line shifts every clk regardless of en so it drains to the frozen raw levels.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hs_p  <= {PIPE_DELAY{~HSPP}};
                    vs_p  <= {PIPE_DELAY{~VSPP}};
                    vld_p <= '0;
                end else begin
                    hs_p[0]  <= hs_raw;
                    vs_p[0]  <= vs_raw;
                    vld_p[0] <= vld_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        hs_p[i]  <= hs_p[i-1];
                        vs_p[i]  <= vs_p[i-1];
                        vld_p[i] <= vld_p[i-1];
                    end
                end
            end

            assign vga.hsync = hs_p[PIPE_DELAY-1];
            assign vga.vsync = vs_p[PIPE_DELAY-1];
            assign vga.valid = vld_p[PIPE_DELAY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 16x8 raster: base, divided clock, delayed,
// inverted-polarity and narrow-frame-counter instances run side by side.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.HWIDTH(12), .VWIDTH(12), .FCW(16)) if0(), if1(), if2(), if3();
    vga_timing_gen_if #(.HWIDTH(12), .VWIDTH(12), .FCW(2))  if4();

    vga_timing_gen #(.HACTIVE(8), .HFP_LEN(2), .HSYNC_LEN(3), .HBP_LEN(3),
                     .VACTIVE(4), .VFP_LEN(1), .VSYNC_LEN(2), .VBP_LEN(1),
                     .HSPP(1'b1), .VSPP(1'b1), .CLK_DIV(1), .PIPE_DELAY(0), .FCW(16))
        u0 (.clk(clk), .rst(rst), .vga(if0));
    vga_timing_gen #(.HACTIVE(8), .HFP_LEN(2), .HSYNC_LEN(3), .HBP_LEN(3),
                     .VACTIVE(4), .VFP_LEN(1), .VSYNC_LEN(2), .VBP_LEN(1),
                     .HSPP(1'b1), .VSPP(1'b1), .CLK_DIV(3), .PIPE_DELAY(0), .FCW(16))
        u1 (.clk(clk), .rst(rst), .vga(if1));
    vga_timing_gen #(.HACTIVE(8), .HFP_LEN(2), .HSYNC_LEN(3), .HBP_LEN(3),
                     .VACTIVE(4), .VFP_LEN(1), .VSYNC_LEN(2), .VBP_LEN(1),
                     .HSPP(1'b1), .VSPP(1'b1), .CLK_DIV(1), .PIPE_DELAY(2), .FCW(16))
        u2 (.clk(clk), .rst(rst), .vga(if2));
    vga_timing_gen #(.HACTIVE(8), .HFP_LEN(2), .HSYNC_LEN(3), .HBP_LEN(3),
                     .VACTIVE(4), .VFP_LEN(1), .VSYNC_LEN(2), .VBP_LEN(1),
                     .HSPP(1'b0), .VSPP(1'b0), .CLK_DIV(1), .PIPE_DELAY(0), .FCW(16))
        u3 (.clk(clk), .rst(rst), .vga(if3));
    vga_timing_gen #(.HACTIVE(8), .HFP_LEN(2), .HSYNC_LEN(3), .HBP_LEN(3),
                     .VACTIVE(4), .VFP_LEN(1), .VSYNC_LEN(2), .VBP_LEN(1),
                     .HSPP(1'b1), .VSPP(1'b1), .CLK_DIV(1), .PIPE_DELAY(0), .FCW(2))
        u4 (.clk(clk), .rst(rst), .vga(if4));

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int hs_exp(input int h);
        return (h >= 10 && h <= 12) ? 1 : 0;
    endfunction

    function automatic int vs_exp(input int v);
        return (v >= 5 && v <= 6) ? 1 : 0;
    endfunction

    function automatic int vld_exp(input int h, input int v);
        return (h < 8 && v < 4) ? 1 : 0;
    endfunction

    task automatic set_en(input logic e);
        if0.en = e; if1.en = e; if2.en = e; if3.en = e; if4.en = e;
    endtask

    // Two reset edges with en low, reset state checked, then release with en high at a negedge.
    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        set_en(1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_h0", if0.hdata, 0);
        check("rst_v0", if0.vdata, 0);
        check("rst_fc0", if0.frame_count, 0);
        check("rst_hs0", if0.hsync, 0);
        check("rst_tick0", if0.pix_tick, 0);
        check("rst_h1", if1.hdata, 0);
        check("rst_hs2", if2.hsync, 0);
        check("rst_vld2", if2.valid, 0);
        check("rst_hs3", if3.hsync, 1);
        check("rst_vs3", if3.vsync, 1);
        check("rst_fc4", if4.frame_count, 0);
        rst = 1'b0;
        set_en(1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_en(1'b0);

        // Free run over five frames on every instance.
        do_reset();
        for (int n = 0; n < 650; n++) begin
            int h, v, n1, h1, v1, tk1, ls1, nd, hd, vd;
            #1;
            h = n % 16;
            v = (n / 16) % 8;
            check($sformatf("h0@%0d", n), if0.hdata, h);
            check($sformatf("v0@%0d", n), if0.vdata, v);
            check($sformatf("hs0@%0d", n), if0.hsync, hs_exp(h));
            check($sformatf("vs0@%0d", n), if0.vsync, vs_exp(v));
            check($sformatf("vld0@%0d", n), if0.valid, vld_exp(h, v));
            check($sformatf("ls0@%0d", n), if0.line_start, (h == 0) ? 1 : 0);
            check($sformatf("fs0@%0d", n), if0.frame_start, (n % 128 == 0) ? 1 : 0);
            check($sformatf("fc0@%0d", n), if0.frame_count, n / 128);

            n1  = n / 3;
            h1  = n1 % 16;
            v1  = (n1 / 16) % 8;
            tk1 = (n % 3 == 2) ? 1 : 0;
            ls1 = (tk1 == 1 && h1 == 0) ? 1 : 0;
            check($sformatf("tick1@%0d", n), if1.pix_tick, tk1);
            check($sformatf("h1@%0d", n), if1.hdata, h1);
            check($sformatf("v1@%0d", n), if1.vdata, v1);
            check($sformatf("ls1@%0d", n), if1.line_start, ls1);
            check($sformatf("fs1@%0d", n), if1.frame_start, (ls1 == 1 && v1 == 0) ? 1 : 0);

            if (n < 2) begin
                check($sformatf("hs2@%0d", n), if2.hsync, 0);
                check($sformatf("vs2@%0d", n), if2.vsync, 0);
                check($sformatf("vld2@%0d", n), if2.valid, 0);
            end else begin
                nd = n - 2;
                hd = nd % 16;
                vd = (nd / 16) % 8;
                check($sformatf("hs2@%0d", n), if2.hsync, hs_exp(hd));
                check($sformatf("vs2@%0d", n), if2.vsync, vs_exp(vd));
                check($sformatf("vld2@%0d", n), if2.valid, vld_exp(hd, vd));
            end

            check($sformatf("hs3@%0d", n), if3.hsync, 1 - hs_exp(h));
            check($sformatf("vs3@%0d", n), if3.vsync, 1 - vs_exp(v));
            check($sformatf("vld3@%0d", n), if3.valid, vld_exp(h, v));
            check($sformatf("fc4@%0d", n), if4.frame_count, (n / 128) % 4);
            @(negedge clk);
        end

        // Stall for 10 clks at hdata=5, vdata=2.
        do_reset();
        repeat (37) @(negedge clk);
        if0.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("stall_h@%0d", i), if0.hdata, 5);
            check($sformatf("stall_v@%0d", i), if0.vdata, 2);
            check($sformatf("stall_tick@%0d", i), if0.pix_tick, 0);
            check($sformatf("stall_ls@%0d", i), if0.line_start, 0);
            check($sformatf("stall_fs@%0d", i), if0.frame_start, 0);
            check($sformatf("stall_vld@%0d", i), if0.valid, 1);
            @(negedge clk);
        end
        if0.en = 1'b1;
        #1;
        check("resume_h", if0.hdata, 5);
        check("resume_tick", if0.pix_tick, 1);
        @(negedge clk);
        #1;
        check("resume_h_next", if0.hdata, 6);
        check("resume_v_next", if0.vdata, 2);

        // Reset just before the frame wrap.
        do_reset();
        repeat (126) @(negedge clk);
        #1;
        check("pre_rst_h", if0.hdata, 14);
        check("pre_rst_v", if0.vdata, 7);
        check("pre_rst_fc", if0.frame_count, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_h", if0.hdata, 0);
        check("mid_rst_v", if0.vdata, 0);
        check("mid_rst_fc", if0.frame_count, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ls", if0.line_start, 1);
        check("post_rst_fs", if0.frame_start, 1);
        @(negedge clk);
        #1;
        check("post_rst_h1", if0.hdata, 1);
        check("post_rst_fc1", if0.frame_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator. Successor to the fixed-timing sync counter.
- Adds synchronous reset, a pixel-clock divider and an external stall enable.
- Adds line/frame strobes, a frame counter, and a configurable pipeline delay on the sync/valid outputs so they line up with downstream pixel pipelines.
- Sits between the system clock and the framebuffer/renderer. hdata/vdata drive address generation; the delayed hsync/vsync/valid drive the VGA port.

Parameters:
- HACTIVE, 640, visible pixels per line
- HFP_LEN, 16, horizontal front porch (pixels)
- HSYNC_LEN, 96, horizontal sync width (pixels)
- HBP_LEN, 48, horizontal back porch (pixels)
- VACTIVE, 480, visible lines per frame
- VFP_LEN, 10, vertical front porch (lines)
- VSYNC_LEN, 2, vertical sync width (lines)
- VBP_LEN, 33, vertical back porch (lines)
- HSPP, 1, hsync active level
- VSPP, 1, vsync active level
- CLK_DIV, 1, clk cycles per pixel (>=1)
- PIPE_DELAY, 0, clk-cycle delay applied to hsync/vsync/valid (0..8)
- HWIDTH, 12, hdata width
- VWIDTH, 12, vdata width
- FCW, 16, frame_count width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run enable; 0 freezes divider and counters
- pix_tick  out  1  pixel-advance strobe (undelayed)
- hdata  out  HWIDTH  current pixel column (undelayed)
- vdata  out  VWIDTH  current line (undelayed)
- line_start  out  1  1-clk strobe at hdata==0
- frame_start  out  1  1-clk strobe at hdata==0, vdata==0
- frame_count  out  FCW  completed-frame counter
- hsync  out  1  horizontal sync, delayed PIPE_DELAY
- vsync  out  1  vertical sync, delayed PIPE_DELAY
- valid  out  1  active-video flag, delayed PIPE_DELAY

Behaviour:
- Derived constants: HMAX = HACTIVE+HFP_LEN+HSYNC_LEN+HBP_LEN; VMAX likewise from the V parameters.
- Divider: div_cnt counts 0..CLK_DIV-1 when en=1, then wraps.
  - pix_tick = en && div_cnt==CLK_DIV-1 (combinational).
  - CLK_DIV=1 gives pix_tick = en.
- hdata: on pix_tick, HMAX-1 wraps to 0, otherwise +1.
- vdata: advances only on pix_tick with hdata==HMAX-1; VMAX-1 wraps to 0.
- frame_count: +1 on pix_tick with hdata==HMAX-1 and vdata==VMAX-1. Wraps modulo 2^FCW, no saturation.
- line_start = pix_tick && hdata==0.
- frame_start = line_start && vdata==0.
  - Both are combinational and last exactly one clk even when CLK_DIV>1.
- Raw sync/valid terms (combinational from counters):
  - hs_raw = HSPP when HACTIVE+HFP_LEN <= hdata < HACTIVE+HFP_LEN+HSYNC_LEN, else !HSPP.
  - vs_raw = VSPP when VACTIVE+VFP_LEN <= vdata < VACTIVE+VFP_LEN+VSYNC_LEN, else !VSPP.
  - valid_raw = hdata<HACTIVE && vdata<VACTIVE.
- Delay line: hsync/vsync/valid equal the raw terms delayed PIPE_DELAY clk cycles through a shift register.
  - The shift register advances every clk, independent of en.
  - PIPE_DELAY=0 means the outputs are the raw terms directly.
- Reset (rst=1 at clk edge), overriding en:
  - div_cnt=0, hdata=0, vdata=0, frame_count=0.
  - Every delay stage loads !HSPP / !VSPP / 0.
  - First cycle after reset: pix_tick and line_start follow en.
    - CLK_DIV=1, en=1: frame_start=1 on that first cycle.
    - CLK_DIV>1: frame_start=1 after CLK_DIV-1 further cycles.
- Reset mid-frame: counters return to 0 immediately; no frame_count increment.
- en=0: divider, counters and frame_count hold, and pix_tick/line_start/frame_start are 0. The delay line keeps shifting, so it drains to the frozen raw values after PIPE_DELAY cycles.
- Elaboration checks (reject at elaboration):
  - HMAX <= 2^HWIDTH and VMAX <= 2^VWIDTH.
  - CLK_DIV >= 1.
  - Every porch/sync length >= 1.
- Default parameters give 640x480@60 with CLK_DIV=4 from 100 MHz.

Test Plan:
- Small config: HACTIVE=8, HFP=2, HSYNC=3, HBP=3 (HMAX=16); VACTIVE=4, VFP=1, VSYNC=2, VBP=1 (VMAX=8); CLK_DIV=1, PIPE_DELAY=0; rst 2 cycles then en=1 -> hsync=1 exactly for hdata 10..12, valid for hdata 0..7 on vdata 0..3, vsync=1 for vdata 5..6, frame_start every 128 clks, frame_count=3 after 384 clks.
- Same config, CLK_DIV=3 -> hdata advances every 3rd clk, line_start one-clk wide every 48 clks, frame period 384 clks.
- PIPE_DELAY=2 -> hsync/vsync/valid equal the PIPE_DELAY=0 waveform shifted by exactly 2 clks; first 2 post-reset cycles show inactive levels.
- HSPP=0, VSPP=0 -> sync waveforms inverted, idle-high; valid unchanged.
- en deasserted for 10 clks at hdata=5, vdata=2 -> counters hold 5/2, no strobes; resume continues at hdata=6 with no skip.
- rst pulsed at hdata=14, vdata=7 (just before frame wrap) -> hdata=vdata=0, frame_count unchanged from its pre-reset value without incrementing; FCW=2 run of 5 frames -> frame_count wraps 3->0.
